uart_xcvr: RTL and testbench

// Parametrised full-duplex UART transceiver; next generation of the Pi-link
// IDC3/IDC1 loopback path. Provides a real TX/RX serial engine with a

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_baud_gen.sv | 25 ++
 rtl/uart_xcvr.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for uart_xcvr: engine state enums, debug view, baud divider.
// Defining UART_PARITY_EN adds a PARITY state to both engines.
package uart_pkg;

  // Wide enough to index up to 9 data bits or 2 stop bits.
  localparam int BIT_IDX_W = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef struct packed {
    rx_state_e rx_state;
    tx_state_e tx_state;
  } uart_dbg_t;

  function automatic int uart_calc_div(input int clk_hz, input int baud, input int os);
    int den;
    int div;
    den = baud * os;
    div = (clk_hz + den / 2) / den;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-clock tick every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver with run-time loopback; one shared baud tick feeds both engines.
// Optional parity bit is enabled by defining UART_PARITY_EN.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic                 tx_pin,
  input  logic                 loopback,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 tx_busy,
  output logic                 rx_busy
);

  localparam int DIV  = uart_calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]      OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] DATA_LAST = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] STOP_LAST = BIT_IDX_W'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("uart_xcvr: OVERSAMPLE must be even and >= 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_db
    $error("uart_xcvr: DATA_BITS must be 5..9");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_sb
    $error("uart_xcvr: STOP_BITS must be 1 or 2");
  end
  if ((PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_par
    $error("uart_xcvr: PARITY_ODD must be 0 or 1");
  end

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // [0] meta, [1] synchronised line, [2] previous synchronised value for edge detect.
  logic [2:0]           rx_pipe_q, rx_pipe_d;
  rx_state_e            rx_state_q, rx_state_d;
  logic [OS_W-1:0]      rx_os_q, rx_os_d;
  logic [BIT_IDX_W-1:0] rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
`ifdef UART_PARITY_EN
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_pend_q, rx_pend_d;
`endif

  logic rx_sync;
  assign rx_sync = rx_pipe_q[1];

  always_comb begin
    rx_pipe_d  = {rx_pipe_q[1:0], rx_pin};
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
    rx_pend_d  = rx_pend_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_pipe_q[2] && !rx_sync) begin
          rx_state_d = RX_START;
          rx_os_d    = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_os_q == OS_HALF) begin
            // From here on every OVERSAMPLE ticks lands on a bit centre.
            rx_os_d    = '0;
            rx_idx_d   = '0;
            rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_os_d = rx_os_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_os_q == OS_LAST) begin
            rx_os_d  = '0;
            rx_sh_d  = {rx_sync, rx_sh_q[DATA_BITS-1:1]};
            rx_idx_d = rx_idx_q + 1'b1;
            if (rx_idx_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
              rx_state_d = RX_PARITY;
`else
              rx_state_d = RX_STOP;
`endif
            end
          end else begin
            rx_os_d = rx_os_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          if (rx_os_q == OS_LAST) begin
            rx_os_d    = '0;
            rx_pend_d  = rx_sync ^ (^rx_sh_q) ^ PAR_ODD;
            rx_state_d = RX_STOP;
          end else begin
            rx_os_d = rx_os_q + 1'b1;
          end
        end
      end
`endif
      RX_STOP: begin
        if (tick) begin
          if (rx_os_q == OS_LAST) begin
            rx_os_d    = '0;
            rx_data_d  = rx_sh_q;
            rx_ferr_d  = !rx_sync;
            rx_valid_d = 1'b1;
            rx_state_d = RX_IDLE;
`ifdef UART_PARITY_EN
            rx_perr_d  = rx_pend_q;
`endif
          end else begin
            rx_os_d = rx_os_q + 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_pipe_q  <= 3'b111;
      rx_state_q <= RX_IDLE;
      rx_os_q    <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
      rx_pend_q  <= 1'b0;
`endif
    end else begin
      rx_pipe_q  <= rx_pipe_d;
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
      rx_perr_q  <= rx_perr_d;
      rx_pend_q  <= rx_pend_d;
`endif
    end
  end

  // TX handshake: a byte transfers on any clock where tx_valid && tx_ready are both high;
  // tx_valid may be raised at any time, tx_ready never depends combinationally on tx_valid.
  tx_state_e            tx_state_q, tx_state_d;
  logic [OS_W-1:0]      tx_os_q, tx_os_d;
  logic [BIT_IDX_W-1:0] tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_pin_q, tx_pin_d;
  logic                 tx_ready_q, tx_ready_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  logic tx_bit_end;
  assign tx_bit_end = tick && (tx_os_q == OS_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_pin_d   = tx_pin_q;
    tx_ready_d = tx_ready_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tick && (tx_state_q != TX_IDLE)) tx_os_d = tx_bit_end ? '0 : tx_os_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          tx_state_d = TX_START;
          tx_sh_d    = tx_data;
          tx_os_d    = '0;
          tx_pin_d   = 1'b0;
          tx_ready_d = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = (^tx_data) ^ PAR_ODD;
`endif
        end else if (loopback) begin
          // pipe[0] registered again matches the 2-clock synchroniser latency.
          tx_pin_d   = rx_pipe_q[0];
          tx_ready_d = 1'b0;
        end else begin
          tx_pin_d   = 1'b1;
          tx_ready_d = 1'b1;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_idx_d   = '0;
          tx_pin_d   = tx_sh_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_idx_q == DATA_LAST) begin
            tx_idx_d = '0;
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
            tx_pin_d   = tx_par_q;
`else
            tx_state_d = TX_STOP;
            tx_pin_d   = 1'b1;
`endif
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_pin_d = tx_sh_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = TX_STOP;
          tx_idx_d   = '0;
          tx_pin_d   = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_idx_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
            tx_ready_d = !loopback;
            tx_pin_d   = loopback ? rx_pipe_q[0] : 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_os_q    <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_pin_q   <= 1'b1;
      tx_ready_q <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_os_q    <= tx_os_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_pin_q   <= tx_pin_d;
      tx_ready_q <= tx_ready_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // Debug view of both engines; busy outputs decode from it.
  uart_dbg_t dbg;
  assign dbg = '{rx_state: rx_state_q, tx_state: tx_state_q};

  assign tx_pin       = tx_pin_q;
  assign tx_ready     = tx_ready_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_ferr_q;
  assign tx_busy      = (dbg.tx_state != TX_IDLE);
  assign rx_busy      = (dbg.rx_state != RX_IDLE);
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// Self-checking bench for uart_xcvr at 16 clocks per bit (DIV=1).
// Honours UART_PARITY_EN when defined for the build.
`timescale 1ns/1ps
module tb_uart_xcvr;

  localparam int CLK_HZ  = 1843200;
  localparam int BAUD    = 115200;
  localparam int OS      = 16;
  localparam int DB      = 8;
  localparam int SB      = 1;
  localparam int PODD    = 0;
  localparam int BIT_CLK = 16;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_BITS = 1 + DB + (PAR_EN ? 1 : 0) + SB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic       loopback = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_pin, tx_ready, rx_valid, rx_frame_err, rx_parity_err, tx_busy, rx_busy;
  logic [7:0] rx_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] rx_exp_q[$];   // {parity_err, frame_err, data}
  logic [7:0] tx_exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } rx_vec_t;

  rx_vec_t    rx_tab[8];
  logic [7:0] tx_tab[6];

  uart_xcvr #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_pin        (rx_pin),
    .tx_pin        (tx_pin),
    .loopback      (loopback),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .tx_busy       (tx_busy),
    .rx_busy       (rx_busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // RX scoreboard: every strobe pops one expected record.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_exp_q.size() == 0) begin
        check("rx_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = rx_exp_q.pop_front();
        check("rx_data", rx_data, e[7:0]);
        check("rx_frame_err", rx_frame_err, e[8]);
        check("rx_parity_err", rx_parity_err, e[9]);
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_pin = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop, input logic par);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);
    rx_pin = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // Drives one byte and checks the serial line clock by clock against the popped expectation.
  task automatic tx_frame(input logic [7:0] d, input logic ready_after);
    logic [7:0]  e;
    logic [15:0] fb;
    int bad;
    int rdy_low;
    tx_exp_q.push_back(d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
    check("tx_busy_after_accept", tx_busy, 1'b1);
    e  = tx_exp_q.pop_front();
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < DB; i++) fb[1 + i] = e[i];
    if (PAR_EN) fb[1 + DB] = (^e) ^ PODD[0];
    rdy_low = 0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      bad = 0;
      for (int k = 0; k < BIT_CLK; k++) begin
        if (tx_pin !== fb[b]) bad++;
        if (tx_ready === 1'b0) rdy_low++;
        @(negedge clk);
      end
      check($sformatf("tx_%02h_bit%0d_badclks", e, b), bad, 0);
    end
    check("tx_ready_low_clks", rdy_low, FRAME_BITS * BIT_CLK);
    check("tx_ready_after_frame", tx_ready, ready_after);
  endtask

  task automatic lb_follow(input int n);
    logic cur, h1, h2;
    int bad, rdy_hi, acc;
    bad = 0; rdy_hi = 0; acc = 0;
    h1 = 1'b1; h2 = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      cur = rx_pin;
      if (tx_pin !== h2) bad++;
      if (tx_ready !== 1'b0) rdy_hi++;
      if (tx_busy !== 1'b0) acc++;
      h2 = h1;
      h1 = cur;
    end
    check("lb_follow_badclks", bad, 0);
    check("lb_ready_high_clks", rdy_hi, 0);
    check("lb_tx_accepted_clks", acc, 0);
  endtask

  initial begin
    rx_tab[0] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
    rx_tab[1] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
    rx_tab[2] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};
    rx_tab[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    rx_tab[4] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    rx_tab[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    rx_tab[6] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    rx_tab[7] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
    tx_tab = '{8'hA5, 8'h07, 8'h00, 8'hFF, 8'h3C, 8'h81};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_pin", tx_pin, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_errs", {rx_frame_err, rx_parity_err}, 2'b00);
    check("rst_busy", {tx_busy, rx_busy}, 2'b00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // TX vectors
    for (int i = 0; i < 6; i++) tx_frame(tx_tab[i], 1'b1);

    // RX vectors
    for (int i = 0; i < 8; i++) begin
      rx_exp_q.push_back({PAR_EN & rx_tab[i].exp_perr, rx_tab[i].exp_ferr, rx_tab[i].exp_data});
      rx_frame(rx_tab[i].data, rx_tab[i].stop, rx_tab[i].par);
      check($sformatf("rx_vec%0d_strobed", i), rx_exp_q.size(), 0);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      rx_exp_q.push_back({2'b00, d});
      rx_frame(d, 1'b1, (^d) ^ PODD[0]);
      check("rx_rand_strobed", rx_exp_q.size(), 0);
    end

    // Short glitch on idle line is a false start
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    rx_pin = 1'b1;
    check("glitch_rx_busy", rx_busy, 1'b1);
    repeat (30) @(negedge clk);
    check("glitch_rx_idle", rx_busy, 1'b0);

    // Reset in the middle of bit 3 of 0xA5 (bit 3 is 0)
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (71) @(negedge clk);
    check("midtx_pin_before_rst", tx_pin, 1'b0);
    check("midtx_ready_before_rst", tx_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("midtx_rst_pin", tx_pin, 1'b1);
    check("midtx_rst_ready", tx_ready, 1'b1);
    check("midtx_rst_busy", tx_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tx_frame(8'h5A, 1'b1);

    // Loopback requested mid-frame: frame completes, then TX stays parked
    fork
      tx_frame(8'h3C, 1'b0);
      begin
        repeat (40) @(negedge clk);
        loopback = 1'b1;
      end
    join

    // Loopback echo while RX keeps decoding; pending tx_valid must not be taken
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    rx_exp_q.push_back({2'b00, 8'h96});
    fork
      rx_frame(8'h96, 1'b1, (^8'h96) ^ PODD[0]);
      lb_follow(FRAME_BITS * BIT_CLK + 20);
    join
    check("lb_rx_strobed", rx_exp_q.size(), 0);
    tx_valid = 1'b0;
    @(negedge clk);
    loopback = 1'b0;
    repeat (2) @(negedge clk);
    check("lb_exit_ready", tx_ready, 1'b1);
    check("lb_exit_pin", tx_pin, 1'b1);
    check("lb_exit_busy", tx_busy, 1'b0);

    repeat (10) @(negedge clk);
    check("final_rx_queue", rx_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
